conv_stream_engine: RTL and testbench
=====================================

// Module: conv_stream_engine
// PURPOSE
//  Parametrised successor to the fixed 3x3 convolution datapath. It computes a valid-mode 2D convolution
//  of an HxW unsigned image, read from external synchronous RAM, with a KxK signed kernel held in an
//  internal register file. Stride, bias and optional ReLU are supported. One MAC per cycle.
//  Each result is presented on a valid/ready output port with its output-map address, for the feature-map store.
// PARAMETERS
//  H       28  image height (pixels)
//  W       28  image width (pixels)
//  K       3   kernel side; K*K taps, 1 <= K <= min(H,W)
//  DW      8   pixel width (unsigned)
//  KW      8   kernel coefficient width (signed, two's complement)
//  ACCW    32  accumulator/result width (signed)
//  STRIDE  1   window step in both i and j
//  RELU    0   1: negative results clamp to 0 at output
// PORTS (OH=(H-K)/STRIDE+1, OW=(W-K)/STRIDE+1, AW=$clog2(H*W), OAW=$clog2(OH*OW), TW=$clog2(K*K))
//  clk        in   1     clock, rising edge
//  rst        in   1     asynchronous, active-high reset
//  start      in   1     1-cycle pulse; begins a full frame when in IDLE
//  k_wr_en    in   1     kernel tap write strobe
//  k_wr_idx   in   TW    tap index, row-major (0 = top-left)
//  k_wr_data  in   KW    signed coefficient
//  bias       in   ACCW  signed; sampled at start, loaded into the accumulator for every window
//  img_rd_en  out  1     image RAM read strobe
//  img_addr   out  AW    pixel address = row*W + col
//  img_data   in   DW    RAM read data, valid exactly 1 cycle after img_rd_en
//  out_valid  out  1     result available
//  out_ready  in   1     consumer accepts when out_valid && out_ready
//  out_data   out  ACCW  convolution result (after ReLU if RELU=1)
//  out_addr   out  OAW   output address = oi*OW + oj
//  busy       out  1     high in every state except IDLE
//  done       out  1     1-cycle pulse after the last result is accepted
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0. Window counters, tap counter, accumulator and kernel registers clear to 0.
//  FSM: IDLE -> FETCH -> DRAIN -> OUT -> (FETCH | DONE) -> IDLE.
//   IDLE: start=1 latches bias, sets oi=oj=0, goes to FETCH. start is ignored in all other states.
//   FETCH: lasts K*K cycles. Tap t (t=0..K*K-1, r=t/K, c=t%K) drives img_rd_en=1 and
//     img_addr=(oi*STRIDE+r)*W + (oj*STRIDE+c). At t=0 the accumulator loads the bias.
//     From the 2nd FETCH cycle on, the accumulator adds img_data*kernel[t-1].
//   DRAIN: 1 cycle; img_rd_en=0; adds the last product (tap K*K-1).
//   OUT: out_valid=1; out_data/out_addr are held stable until the handshake, regardless of out_ready.
//     Handshake on the last window (oi=OH-1, oj=OW-1) -> DONE; otherwise advance oj, wrap to 0 and
//     increment oi at OW-1, then go to FETCH.
//   DONE: done=1 for 1 cycle, busy still 1; then IDLE.
//  Arithmetic: zero-extend the pixel to DW+1 and multiply signed by the coefficient (DW+KW+1 bits).
//   Sign-extend the product to ACCW. Accumulation wraps modulo 2^ACCW (no saturation).
//  ReLU: if RELU=1 and acc[ACCW-1]=1, out_data=0. out_addr is unaffected.
//  Latency: with out_ready held high, each window takes K*K+2 cycles.
//   Frame = OH*OW*(K*K+2)+1 cycles from the start pulse to the done pulse.
//  Kernel writes: accepted only in IDLE. Ignored while busy=1, so coefficients stay stable for the whole frame.
//   Writes in the same cycle as start are accepted and apply to that frame.
//  Reset mid-frame: immediate return to IDLE. out_valid and busy drop asynchronously. The kernel is cleared
//   and must be reloaded.
//  Stride remainder: rows/cols beyond (OH-1)*STRIDE+K-1 are never read.
// TESTING
//  T1 H=W=4,K=3,S=1, pixels=addr, kernel centre=1 others 0, bias=0 -> 4 results 5,6,9,10 at out_addr 0..3;
//   done on cycle 4*11+1 after start.
//  T2 H=W=5,K=3,STRIDE=2, all pixels=1, all taps=2, bias=-3 -> 4 results of 15.
//   img_addr of the first tap of each window: 0,2,10,12.
//  T3 RELU=1, pixels=255, all taps=-128, bias=0 -> out_data=0. Same with RELU=0 -> -293760.
//  T4 out_ready low for 6 cycles in OUT -> out_valid, out_data and out_addr stable; no new img_rd_en;
//   accepted on the first ready cycle.
//  T5 k_wr_en and start pulsed mid-frame -> no kernel change, no restart; results match the golden model.
//  T6 rst asserted during FETCH of window 2 -> busy=0, out_valid=0 at once.
//   Reload kernel, start again -> full correct frame from out_addr 0.

Source files
------------

// File: rtl/conv_stream_engine.sv
// conv_stream_engine: streaming valid-mode KxK 2D convolution, one MAC per cycle, over an external sync image RAM
//   clk, rst                      clock, asynchronous active-high reset
//   start                         frame start pulse (honoured in IDLE only)
//   k_wr_en, k_wr_idx, k_wr_data  kernel tap write port (honoured in IDLE only)
//   bias                          signed accumulator preload, latched at start
//   img_rd_en, img_addr, img_data image RAM read port (data one cycle after strobe)
//   out_valid, out_ready          result handshake
//   out_data, out_addr            result value and output-map address
//   busy, done                    frame in progress / end-of-frame pulse
module conv_stream_engine #(
   parameter int H      = 28,
   parameter int W      = 28,
   parameter int K      = 3,
   parameter int DW     = 8,
   parameter int KW     = 8,
   parameter int ACCW   = 32,
   parameter int STRIDE = 1,
   parameter int RELU   = 0,
   localparam int OH    = (H - K) / STRIDE + 1,
   localparam int OW    = (W - K) / STRIDE + 1,
   localparam int AW    = (H * W > 1) ? $clog2(H * W) : 1,
   localparam int OAW   = (OH * OW > 1) ? $clog2(OH * OW) : 1,
   localparam int TW    = (K * K > 1) ? $clog2(K * K) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   k_wr_en,
   input  logic [TW-1:0]          k_wr_idx,
   input  logic signed [KW-1:0]   k_wr_data,
   input  logic signed [ACCW-1:0] bias,
   output logic                   img_rd_en,
   output logic [AW-1:0]          img_addr,
   input  logic [DW-1:0]          img_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [ACCW-1:0] out_data,
   output logic [OAW-1:0]         out_addr,
   output logic                   busy,
   output logic                   done
);
   localparam int NT = K * K;
   localparam int CW = (K > 1) ? $clog2(K) : 1;
   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUT, DONE} state_t;
   state_t state, state_nx;
   logic [TW-1:0] t, pt;
   logic [CW-1:0] r, c;
   logic [OAW-1:0] oi, oj;
   logic signed [ACCW-1:0] acc, bias_q;
   logic signed [KW-1:0] kern [NT];
   logic signed [DW+KW:0] prod;
   logic [31:0] addr_full, oaddr_full;
   logic last_tap, last_win, row_end;
   assign last_tap   = t == TW'(NT - 1);
   assign last_win   = oi == OAW'(OH - 1) && oj == OAW'(OW - 1);
   assign row_end    = c == CW'(K - 1);
   // pt trails t by one cycle, matching the one-cycle RAM read latency
   assign prod       = $signed({1'b0, img_data}) * kern[pt];
   assign addr_full  = (32'(oi) * STRIDE + 32'(r)) * W + 32'(oj) * STRIDE + 32'(c);
   assign oaddr_full = 32'(oi) * OW + 32'(oj);
   assign img_addr   = img_rd_en ? addr_full[AW-1:0] : '0;
   assign out_addr   = oaddr_full[OAW-1:0];
   assign out_data   = (RELU != 0 && acc[ACCW-1]) ? '0 : acc;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx  = state;
      img_rd_en = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nx = FETCH;
         end
         FETCH: begin
            img_rd_en = 1'b1;
            if (last_tap) state_nx = DRAIN;
         end
         DRAIN: state_nx = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = last_win ? DONE : FETCH;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t      <= '0;
         pt     <= '0;
         r      <= '0;
         c      <= '0;
         oi     <= '0;
         oj     <= '0;
         acc    <= '0;
         bias_q <= '0;
         for (int i = 0; i < NT; i++) kern[i] <= '0;
      end else begin
         if (state == IDLE && k_wr_en && int'(k_wr_idx) < NT) kern[k_wr_idx] <= k_wr_data;
         if (state == IDLE && start) begin
            bias_q <= bias;
            oi     <= '0;
            oj     <= '0;
            t      <= '0;
            r      <= '0;
            c      <= '0;
         end
         if (state == FETCH) begin
            pt  <= t;
            t   <= last_tap ? '0 : t + TW'(1);
            c   <= row_end ? '0 : c + CW'(1);
            r   <= row_end ? (last_tap ? '0 : r + CW'(1)) : r;
            // first fetch cycle has no data back yet, so it seeds the bias instead
            acc <= (t == '0) ? bias_q : acc + ACCW'(prod);
         end
         if (state == DRAIN) acc <= acc + ACCW'(prod);
         if (state == OUT && out_ready && !last_win) begin
            oj <= (oj == OAW'(OW - 1)) ? '0 : oj + OAW'(1);
            oi <= (oj == OAW'(OW - 1)) ? oi + OAW'(1) : oi;
         end
      end
   end
endmodule

// File: tb/tb_conv_stream_engine.sv
// tb_conv_stream_engine: directed self-checking bench for conv_stream_engine
module tb_conv_stream_engine;
   logic clk = 1'b0, rst, start, k_wr_en, out_ready;
   logic [3:0] k_wr_idx;
   logic signed [7:0] k_wr_data;
   logic signed [31:0] bias;
   logic rd0, rd1, rd2, ov0, ov1, ov2, busy0, busy1, busy2, done0, done1, done2;
   logic [3:0] addr0, addr2;
   logic [4:0] addr1;
   logic [7:0] data0, data1, data2;
   logic signed [31:0] od0, od1, od2, hd;
   logic [1:0] oa0, oa1, oa2, ha;
   logic [7:0] mem0 [16];
   logic [7:0] mem1 [25];
   logic [7:0] mem2 [16];
   int n_chk = 0, n_pass = 0;
   int cyc, stall, unstable, rd_in_out, first_acc, done_cyc;
   bit got_done, aborted, prev1;
   logic signed [31:0] r0[$], r1[$], r2[$];
   int a0[$], a1[$], f1[$];
   int t1_exp[4] = '{5, 6, 9, 10};
   int t2_first[4] = '{0, 2, 10, 12};

   always #5 clk = ~clk;

   conv_stream_engine #(.H(4), .W(4)) u0 (
      .clk(clk), .rst(rst), .start(start), .k_wr_en(k_wr_en), .k_wr_idx(k_wr_idx),
      .k_wr_data(k_wr_data), .bias(bias), .img_rd_en(rd0), .img_addr(addr0), .img_data(data0),
      .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_addr(oa0), .busy(busy0), .done(done0));
   conv_stream_engine #(.H(5), .W(5), .STRIDE(2)) u1 (
      .clk(clk), .rst(rst), .start(start), .k_wr_en(k_wr_en), .k_wr_idx(k_wr_idx),
      .k_wr_data(k_wr_data), .bias(bias), .img_rd_en(rd1), .img_addr(addr1), .img_data(data1),
      .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_addr(oa1), .busy(busy1), .done(done1));
   conv_stream_engine #(.H(4), .W(4), .RELU(1)) u2 (
      .clk(clk), .rst(rst), .start(start), .k_wr_en(k_wr_en), .k_wr_idx(k_wr_idx),
      .k_wr_data(k_wr_data), .bias(bias), .img_rd_en(rd2), .img_addr(addr2), .img_data(data2),
      .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_addr(oa2), .busy(busy2), .done(done2));

   always @(posedge clk) begin
      if (rd0) data0 <= mem0[addr0];
      if (rd1) data1 <= mem1[addr1];
      if (rd2) data2 <= mem2[addr2];
   end

   task automatic check(string tag, logic signed [31:0] got, logic signed [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic cycle();
      @(negedge clk);
      if ((done0 || done1) && !got_done) begin
         got_done = 1;
         done_cyc = cyc;
      end
      if (ov0 && out_ready) begin
         r0.push_back(od0);
         a0.push_back(32'(oa0));
         if (first_acc < 0) first_acc = cyc;
      end
      if (ov1 && out_ready) begin
         r1.push_back(od1);
         a1.push_back(32'(oa1));
      end
      if (ov2 && out_ready) r2.push_back(od2);
      if (rd1 && !prev1) f1.push_back(32'(addr1));
      prev1 = rd1;
      if (ov0 && !out_ready) begin
         if (stall == 0) begin
            hd = od0;
            ha = oa0;
         end else if (od0 !== hd || oa0 !== ha) unstable++;
         if (rd0) rd_in_out++;
         stall++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wr_tap(int idx, int d);
      k_wr_en = 1'b1;
      k_wr_idx = 4'(idx);
      k_wr_data = 8'(d);
      cycle();
      k_wr_en = 1'b0;
   endtask

   task automatic load_centre();
      for (int i = 0; i < 9; i++) wr_tap(i, (i == 4) ? 1 : 0);
   endtask

   task automatic load_all(int d);
      for (int i = 0; i < 9; i++) wr_tap(i, d);
   endtask

   task automatic run_frame(int mode);
      r0.delete(); r1.delete(); r2.delete(); a0.delete(); a1.delete(); f1.delete();
      stall = 0; unstable = 0; rd_in_out = 0; first_acc = -1; done_cyc = -1;
      got_done = 0; aborted = 0; prev1 = 0;
      start = 1'b1;
      cyc = 0;
      while (!got_done && !aborted && cyc < 400) begin
         cycle();
         start = 1'b0;
         k_wr_en = 1'b0;
         if (mode == 5 && (cyc == 5 || cyc == 20)) begin
            start = 1'b1;
            k_wr_en = 1'b1;
            k_wr_idx = 4'd4;
            k_wr_data = 8'sd7;
         end
         if (mode == 4 && stall == 6) out_ready = 1'b1;
         if (mode == 6 && cyc == 25) begin
            check("t6_busy_before", 32'(busy0), 1);
            rst = 1'b1;
            #1;
            check("t6_busy_async", 32'(busy0), 0);
            check("t6_valid_async", 32'(ov0), 0);
            aborted = 1;
         end
      end
      if (!aborted) check("done_seen", 32'(got_done), 1);
   endtask

   task automatic check_t1(string tag);
      check({tag, "_count"}, r0.size(), 4);
      for (int i = 0; i < 4 && i < r0.size(); i++) begin
         check($sformatf("%s_data%0d", tag, i), r0[i], t1_exp[i]);
         check($sformatf("%s_addr%0d", tag, i), a0[i], i);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; k_wr_en = 1'b0; k_wr_idx = '0; k_wr_data = '0;
      bias = '0; out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         mem0[i] = 8'(i);
         mem2[i] = 8'(i);
      end
      for (int i = 0; i < 25; i++) mem1[i] = 8'd1;
      repeat (3) cycle();
      check("rst_busy", 32'(busy0), 0);
      check("rst_valid", 32'(ov0), 0);
      check("rst_done", 32'(done0), 0);
      check("rst_rd_en", 32'(rd0), 0);
      check("rst_img_addr", 32'(addr0), 0);
      check("rst_out_data", od0, 0);
      check("rst_out_addr", 32'(oa0), 0);
      rst = 1'b0;
      cycle();
      // T1: centre tap picks the window centre pixel
      load_centre();
      run_frame(0);
      check_t1("t1");
      check("t1_done_cycle", done_cyc, 45);
      cycle();
      check("t1_done_pulse", 32'(done0), 0);
      check("t1_idle", 32'(busy0), 0);
      // T5: mid-frame start and kernel writes are ignored
      run_frame(5);
      check_t1("t5");
      check("t5_done_cycle", done_cyc, 45);
      // T4: six-cycle back-pressure on the first window
      out_ready = 1'b0;
      run_frame(4);
      check("t4_stall_len", stall, 6);
      check("t4_unstable", unstable, 0);
      check("t4_rd_in_out", rd_in_out, 0);
      check("t4_accept_cycle", first_acc, 17);
      check("t4_done_cycle", done_cyc, 51);
      check_t1("t4");
      // T2: stride 2 on 5x5, 9*1*2 - 3
      cycle();
      load_all(2);
      bias = -3;
      run_frame(0);
      check("t2_count", r1.size(), 4);
      check("t2_taps", f1.size(), 4);
      for (int i = 0; i < 4 && i < r1.size() && i < f1.size(); i++) begin
         check($sformatf("t2_data%0d", i), r1[i], 15);
         check($sformatf("t2_addr%0d", i), a1[i], i);
         check($sformatf("t2_first_tap%0d", i), f1[i], t2_first[i]);
      end
      // T3: 9*255*-128 with and without ReLU
      cycle();
      for (int i = 0; i < 16; i++) begin
         mem0[i] = 8'd255;
         mem2[i] = 8'd255;
      end
      load_all(-128);
      bias = 0;
      run_frame(0);
      check("t3_count", r0.size(), 4);
      check("t3_relu_count", r2.size(), 4);
      for (int i = 0; i < 4 && i < r0.size() && i < r2.size(); i++) begin
         check($sformatf("t3_raw%0d", i), r0[i], -293760);
         check($sformatf("t3_relu%0d", i), r2[i], 0);
      end
      // T6: reset in window 2 clears the kernel; reload and rerun
      cycle();
      for (int i = 0; i < 16; i++) mem0[i] = 8'(i);
      load_centre();
      run_frame(6);
      cycle();
      rst = 1'b0;
      cycle();
      run_frame(0);
      check("t6_cleared_count", r0.size(), 4);
      for (int i = 0; i < 4 && i < r0.size(); i++) check($sformatf("t6_cleared%0d", i), r0[i], 0);
      cycle();
      load_centre();
      run_frame(0);
      check_t1("t6");
      check("t6_done_cycle", done_cyc, 45);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
